sd_write: RTL and testbench
===========================

# sd_write

SPI-mode SD card single-block writer (CMD24) that sits alongside `sd_init` and `sd_read` on the shared CMD/DAT0/DAT3 lines. It runs after `sd_init` completes and writes one 512-byte block from a show-ahead byte source to card address `addr`. It reports success, or the failing R1/data-response byte. It generates its own SPI clock from `clk`, shifts MOSI out and samples MISO in.

## Interface
Parameters:
- `CLK_DIV`, default 2: `clk` cycles per SCLK half-period; minimum 1.
- `R1_TIMEOUT`, default 8: maximum bytes polled for R1 after the command.
- `BUSY_TIMEOUT`, default 65535: maximum bytes polled while the card holds DAT0 low.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: level request; accepted only in IDLE.
- `addr` in 32: CMD24 argument, latched on accept.
- `data_in` in 8: next payload byte; valid in the same cycle as `byte_rd`.
- `byte_rd` out 1: one-cycle pulse that consumes `data_in`.
- `sclk` out 1: SPI clock, idle low (mode 0).
- `cs_n` out 1: card select, drives DAT3.
- `mosi` out 1: drives CMD.
- `miso` in 1: from DAT0.
- `busy` out 1: high from accept until DONE or ERROR.
- `done` out 1: level; high in DONE or ERROR until `start` falls.
- `err` out 1: valid while `done` is high.
- `status` out 8: failing R1 or data-response byte; 0x00 on success.

## Operation
States, in order: IDLE → CMD → R1 → GAP → TOKEN → DATA → CRC → DRESP → BUSY → DONE.
- ERROR is reachable from R1, DRESP and BUSY.
- IDLE: `cs_n`=1 and `mosi`=1. When `start` is high, latch `addr`, set `cs_n`=0, go to CMD.
- CMD: shift 48 bits MSB first: 0x58, `addr[31:0]`, then the CRC/stop byte.
- R1: clock out 0xFF and read bytes. The first byte with bit7=0 is R1.
  - R1 = 0x00 → GAP.
  - R1 ≠ 0x00 → ERROR with `status`=R1.
  - No R1 within `R1_TIMEOUT` bytes → ERROR with `status`=0xFF.
- GAP: one 0xFF byte.
- TOKEN: send 0xFE.
- DATA: 512 bytes, MSB first.
  - `byte_rd` pulses once per byte, in the cycle the byte loads into the shift register.
  - Exactly 512 pulses per transaction, no more.
- CRC: 16 bits. See Configuration.
- DRESP: read bytes until one has bit4=0, polling up to 8 bytes.
  - (byte & 0x1F) == 0x05 → BUSY.
  - Any other value → ERROR with `status`=that byte.
  - No match within 8 bytes → ERROR with `status`=0xFF.
- BUSY: clock out 0xFF while the received byte is 0x00.
  - First nonzero byte → DONE.
  - More than `BUSY_TIMEOUT` bytes → ERROR with `status`=0xFE.
- DONE/ERROR:
  - One trailing 0xFF byte, then `cs_n`=1.
  - `done`=1, `busy`=0; `err`=0 in DONE, 1 in ERROR.
  - Return to IDLE when `start`=0.
- `start` deasserting mid-transaction is ignored; the transaction completes.
- Reset mid-transaction aborts immediately. `cs_n` rises asynchronously and no partial-state recovery is attempted.

## Timing
- Reset values:
  - `cs_n`=1, `mosi`=1, `sclk`=0.
  - `busy`=0, `done`=0, `err`=0, `status`=0x00, `byte_rd`=0.
- `sclk` toggles only when `cs_n`=0 or during the trailing byte. Otherwise it is held low.
- One bit takes 2·`CLK_DIV` `clk` cycles.
- `mosi` updates on the `clk` edge that drives `sclk` low. The first bit is set up one half-period before the first rising edge.
- `miso` is sampled on the `clk` edge that drives `sclk` high.
- Latency from the `start` accept edge to the first `sclk` rise is `CLK_DIV`+1 `clk` cycles.
- `done` rises one `clk` cycle after the trailing byte's last falling edge.
- `byte_rd` for byte n+1 occurs at least 8 bits after `byte_rd` for byte n. The source has 16·`CLK_DIV`−1 cycles to present the next byte.
- Minimum transaction bytes: 6 (CMD) + 1 (R1) + 1 (GAP) + 1 (TOKEN) + 512 (DATA) + 2 (CRC) + 1 (DRESP) + 1 (BUSY) + 1 (trailing) = 526 bytes.
- At `CLK_DIV`=2 that is 526·8·4 = 16832 `clk` cycles.

## Configuration
- Macro: `SD_WRITE_CRC16_EN`.
- Defined:
  - CMD byte 5 is {CRC7 over the first 5 bytes, 1'b1}.
  - The CRC field is CRC16-CCITT (poly 0x1021, init 0x0000) over the 512 data bytes, computed serially as bits shift out.
- Undefined:
  - CMD byte 5 is 0xFF.
  - The CRC field is 0xFFFF.
  - No CRC logic is synthesized.

## Test plan
- Card model returns R1=0x00, data response 0x05, 3 busy bytes of 0x00 → `done`=1, `err`=0, `status`=0x00.
  - Exactly 512 `byte_rd` pulses.
  - Model captures 0x58 00 00 02 00 for `addr`=0x00000200, plus 512 bytes matching the source.
- R1=0x04 (illegal command) → ERROR, `status`=0x04, `err`=1, zero `byte_rd` pulses.
- Data response 0x0B (CRC error) → `status`=0x0B, `err`=1, `cs_n` returns to 1.
- Card never answers (MISO stuck high) → after 8 R1 bytes: `status`=0xFF, `err`=1.
- `reset` pulsed at DATA byte 100 → all outputs return to their reset values within the same cycle. A following `start` completes cleanly.
- With `SD_WRITE_CRC16_EN`, payload of bytes 0x00..0xFF repeated → CMD byte 5 = 0x6F for `addr`=0. CRC field equals the model's CRC16-CCITT over the payload.

Source files
------------

// File: rtl/sd_write.sv
// rtl/sd_write.sv - SPI-mode SD card single-block (CMD24) writer; optional CRC via SD_WRITE_CRC16_EN
module sd_write #(
    parameter int CLK_DIV      = 2,
    parameter int R1_TIMEOUT   = 8,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [7:0]  data_in,
    output logic        byte_rd,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  status
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC,
        S_DRESP, S_BUSY, S_FIN, S_DONE, S_ERROR
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

`ifdef SD_WRITE_CRC16_EN
    // CRC7 (x^7 + x^3 + 1) over the command byte and argument, with stop bit appended
    function automatic logic [7:0] cmd_crc_byte(input logic [31:0] a);
        logic [39:0] m;
        logic [6:0]  c;
        logic        fb;
        m = {8'h58, a};
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = m[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return {c, 1'b1};
    endfunction
`endif

    state_t      state_q, state_d;
    logic [47:0] cmd_q, cmd_d;
    logic [7:0]  tx_q, tx_d, rx_q, rx_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] div_q, div_d;
    logic [16:0] cnt_q, cnt_d;
    logic        act_q, act_d, sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, fail_q, fail_d;
    logic [7:0]  status_q, status_d;
    logic        byte_end, load, rd_pulse;
    logic [7:0]  load_byte;
    logic [15:0] crc_field;
`ifdef SD_WRITE_CRC16_EN
    logic [15:0] crc_q, crc_d;
    assign crc_field = crc_q;
`else
    assign crc_field = 16'hFFFF;
`endif

    // Bit engine (SCLK generation, shifting) plus byte-level protocol sequencing
    always_comb begin
        state_d = state_q; cmd_d = cmd_q; tx_d = tx_q; rx_d = rx_q; bit_d = bit_q;
        div_d = div_q; cnt_d = cnt_q; act_d = act_q; sclk_d = sclk_q; mosi_d = mosi_q;
        cs_n_d = cs_n_q; busy_d = busy_q; done_d = done_q; err_d = err_q;
        fail_d = fail_q; status_d = status_q;
`ifdef SD_WRITE_CRC16_EN
        crc_d = crc_q;
`endif
        byte_end = 1'b0; load = 1'b0; rd_pulse = 1'b0; load_byte = 8'hFF;

        if (act_q) begin
            if (div_q == DIV_LAST) begin
                div_d = 16'd0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], miso};
`ifdef SD_WRITE_CRC16_EN
                    if (state_q == S_DATA)
                        crc_d = {crc_q[14:0], 1'b0} ^ ((mosi_q ^ crc_q[15]) ? 16'h1021 : 16'h0000);
`endif
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q != 3'd0) begin
                        bit_d  = bit_q - 3'd1;
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                    end else begin
                        byte_end = 1'b1;
                    end
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: if (start) begin
`ifdef SD_WRITE_CRC16_EN
                cmd_d = {8'h58, addr, cmd_crc_byte(addr)};
                crc_d = 16'h0000;
`else
                cmd_d = {8'h58, addr, 8'hFF};
`endif
                cs_n_d = 1'b0; busy_d = 1'b1; err_d = 1'b0; fail_d = 1'b0;
                status_d = 8'h00; cnt_d = 17'd0; state_d = S_CMD;
            end
            S_CMD: if (!act_q || byte_end) begin
                load = 1'b1;
                if (cnt_q < 17'd6) begin
                    load_byte = cmd_q[47:40];
                    cmd_d     = {cmd_q[39:0], 8'hFF};
                    cnt_d     = cnt_q + 17'd1;
                end else begin
                    cnt_d = 17'd0; state_d = S_R1;
                end
            end
            S_R1: if (byte_end) begin
                load = 1'b1;
                if (!rx_q[7]) begin
                    if (rx_q == 8'h00) state_d = S_GAP;
                    else begin fail_d = 1'b1; status_d = rx_q; state_d = S_FIN; end
                end else if (cnt_q + 17'd1 >= 17'(R1_TIMEOUT)) begin
                    fail_d = 1'b1; status_d = 8'hFF; state_d = S_FIN;
                end else cnt_d = cnt_q + 17'd1;
            end
            S_GAP: if (byte_end) begin
                load = 1'b1; load_byte = 8'hFE; state_d = S_TOKEN;
            end
            S_TOKEN: if (byte_end) begin
                load = 1'b1; load_byte = data_in; rd_pulse = 1'b1;
                cnt_d = 17'd0; state_d = S_DATA;
            end
            S_DATA: if (byte_end) begin
                load = 1'b1;
                if (cnt_q == 17'd511) begin
                    load_byte = crc_field[15:8]; cnt_d = 17'd0; state_d = S_CRC;
                end else begin
                    load_byte = data_in; rd_pulse = 1'b1; cnt_d = cnt_q + 17'd1;
                end
            end
            S_CRC: if (byte_end) begin
                load = 1'b1;
                if (cnt_q == 17'd0) begin
                    load_byte = crc_field[7:0]; cnt_d = 17'd1;
                end else begin
                    cnt_d = 17'd0; state_d = S_DRESP;
                end
            end
            S_DRESP: if (byte_end) begin
                load = 1'b1;
                if (!rx_q[4]) begin
                    if (rx_q[4:0] == 5'h05) begin cnt_d = 17'd0; state_d = S_BUSY; end
                    else begin fail_d = 1'b1; status_d = rx_q; state_d = S_FIN; end
                end else if (cnt_q + 17'd1 >= 17'd8) begin
                    fail_d = 1'b1; status_d = 8'hFF; state_d = S_FIN;
                end else cnt_d = cnt_q + 17'd1;
            end
            S_BUSY: if (byte_end) begin
                load = 1'b1;
                if (rx_q != 8'h00) state_d = S_FIN;
                else if (cnt_q + 17'd1 >= 17'(BUSY_TIMEOUT)) begin
                    fail_d = 1'b1; status_d = 8'hFE; state_d = S_FIN;
                end else cnt_d = cnt_q + 17'd1;
            end
            S_FIN: if (byte_end) begin
                act_d = 1'b0; cs_n_d = 1'b1;
                state_d = fail_q ? S_ERROR : S_DONE;
            end
            S_DONE, S_ERROR: begin
                busy_d = 1'b0; done_d = 1'b1; err_d = fail_q;
                if (!start && done_q) begin
                    done_d = 1'b0; err_d = 1'b0; state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            tx_d = load_byte; mosi_d = load_byte[7]; bit_d = 3'd7;
            div_d = 16'd0; sclk_d = 1'b0; act_d = 1'b1;
        end
    end

    // State and output registers; reset drops the card select immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE; cmd_q <= '0; tx_q <= 8'hFF; rx_q <= 8'h00; bit_q <= 3'd0;
            div_q <= 16'd0; cnt_q <= 17'd0; act_q <= 1'b0; sclk_q <= 1'b0; mosi_q <= 1'b1;
            cs_n_q <= 1'b1; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; fail_q <= 1'b0;
            status_q <= 8'h00;
`ifdef SD_WRITE_CRC16_EN
            crc_q <= 16'h0000;
`endif
        end else begin
            state_q <= state_d; cmd_q <= cmd_d; tx_q <= tx_d; rx_q <= rx_d; bit_q <= bit_d;
            div_q <= div_d; cnt_q <= cnt_d; act_q <= act_d; sclk_q <= sclk_d; mosi_q <= mosi_d;
            cs_n_q <= cs_n_d; busy_q <= busy_d; done_q <= done_d; err_q <= err_d; fail_q <= fail_d;
            status_q <= status_d;
`ifdef SD_WRITE_CRC16_EN
            crc_q <= crc_d;
`endif
        end
    end

    assign byte_rd = rd_pulse;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign status  = status_q;

endmodule

// File: tb/tb_sd_write.sv
// tb/tb_sd_write.sv - directed self-checking bench for sd_write with a byte-indexed SD card model
module tb_sd_write;

    logic        clk = 1'b0;
    logic        reset, start, miso;
    logic [31:0] addr;
    logic [7:0]  data_in;
    logic        byte_rd, sclk, cs_n, mosi, busy, done, err;
    logic [7:0]  status;

    sd_write dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .data_in(data_in),
        .byte_rd(byte_rd), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .busy(busy), .done(done), .err(err), .status(status)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  resp [0:1023];
    logic [7:0]  cap  [0:1023];
    logic [9:0]  bidx = '0;
    logic [2:0]  bitc = '0;
    logic [7:0]  sh = '0;
    int          rd_cnt = 0;
    logic        rd_clr = 1'b0;
    logic [7:0]  seed = 8'h00;

    // Card model: capture MOSI bytes on SCLK rise, serve scripted response bytes on MISO
    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            bidx <= '0;
            bitc <= '0;
        end else begin
            sh   <= {sh[6:0], mosi};
            bitc <= bitc + 3'd1;
            if (bitc == 3'd7) begin
                cap[bidx] <= {sh[6:0], mosi};
                bidx      <= bidx + 10'd1;
            end
        end
    end

    assign miso = cs_n ? 1'b1 : resp[bidx][3'd7 - bitc];

    // Show-ahead payload source
    always @(posedge clk) begin
        if (rd_clr) rd_cnt <= 0;
        else if (byte_rd) rd_cnt <= rd_cnt + 1;
    end
    assign data_in = rd_cnt[7:0] ^ seed;

    function automatic logic [7:0] pay(input int i);
        return i[7:0] ^ seed;
    endfunction

    function automatic logic [15:0] crc16_model();
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            b = pay(i);
            for (int k = 7; k >= 0; k--)
                c = {c[14:0], 1'b0} ^ ((b[k] ^ c[15]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_resp();
        for (int i = 0; i < 1024; i++) resp[i] = 8'hFF;
    endtask

    task automatic set_good_card();
        clear_resp();
        resp[6]   = 8'h00;
        resp[523] = 8'h05;
        resp[524] = 8'h00;
        resp[525] = 8'h00;
        resp[526] = 8'h00;
    endtask

    task automatic begin_txn(input logic [31:0] a);
        @(negedge clk); rd_clr = 1'b1;
        @(negedge clk); rd_clr = 1'b0; addr = a; start = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_accept", busy, 1'b1);
        chk("cs_n_after_accept", cs_n, 1'b0);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40000; k++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        chk("done_within_budget", ok, 1'b1);
    endtask

    task automatic end_txn();
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_clears", done, 1'b0);
        chk("idle_cs_n", cs_n, 1'b1);
    endtask

    int lat;
    int bad;

    initial begin
        reset = 1'b1; start = 1'b0; addr = '0;
        clear_resp();
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_mosi", mosi, 1'b1);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_flags", {busy, done, err, byte_rd}, 4'b0000);
        chk("rst_status", status, 8'h00);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Good card, addr 0x200
        seed = 8'h5A;
        set_good_card();
        begin_txn(32'h0000_0200);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; lat++;
            if (sclk) break;
        end
        chk("first_sclk_latency", lat, 3);
        wait_done();
        chk("ok_err", err, 1'b0);
        chk("ok_status", status, 8'h00);
        chk("ok_busy_low", busy, 1'b0);
        chk("ok_cs_n", cs_n, 1'b1);
        chk("ok_rd_count", rd_cnt, 512);
        chk("ok_cmd_hi", {cap[0], cap[1], cap[2], cap[3]}, 32'h5800_0002);
        chk("ok_cmd_lo", {cap[4], cap[7], cap[8]}, 24'h00_FF_FE);
`ifdef SD_WRITE_CRC16_EN
`else
        chk("ok_cmd_crc", cap[5], 8'hFF);
        chk("ok_crc_field", {cap[521], cap[522]}, 16'hFFFF);
`endif
        bad = 0;
        for (int i = 0; i < 512; i++) if (cap[9 + i] !== pay(i)) bad++;
        chk("ok_payload_errors", bad, 0);
        end_txn();
        chk("ok_no_extra_rd", rd_cnt, 512);

        // R1 illegal command
        clear_resp();
        resp[6] = 8'h04;
        begin_txn(32'h0000_1000);
        wait_done();
        chk("r1_err", err, 1'b1);
        chk("r1_status", status, 8'h04);
        chk("r1_rd_count", rd_cnt, 0);
        end_txn();

        // Data response CRC error
        set_good_card();
        resp[523] = 8'h0B;
        begin_txn(32'h0000_0400);
        wait_done();
        chk("dresp_err", err, 1'b1);
        chk("dresp_status", status, 8'h0B);
        chk("dresp_cs_n", cs_n, 1'b1);
        end_txn();

        // Card never answers
        clear_resp();
        begin_txn(32'h0000_0000);
        wait_done();
        chk("stuck_err", err, 1'b1);
        chk("stuck_status", status, 8'hFF);
        chk("stuck_rd_count", rd_cnt, 0);
        end_txn();

        // Reset in the middle of the payload
        set_good_card();
        begin_txn(32'h0000_0800);
        lat = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (rd_cnt >= 100) begin lat = 1; break; end
        end
        chk("reach_byte_100", lat, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_cs_n", cs_n, 1'b1);
        chk("mid_rst_pins", {sclk, mosi}, 2'b01);
        chk("mid_rst_flags", {busy, done, err, byte_rd}, 4'b0000);
        chk("mid_rst_status", status, 8'h00);
        start = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean run after reset, addr 0, payload 0x00..0xFF repeating
        seed = 8'h00;
        set_good_card();
        begin_txn(32'h0000_0000);
        wait_done();
        chk("post_err", err, 1'b0);
        chk("post_status", status, 8'h00);
        chk("post_rd_count", rd_cnt, 512);
        bad = 0;
        for (int i = 0; i < 512; i++) if (cap[9 + i] !== pay(i)) bad++;
        chk("post_payload_errors", bad, 0);
`ifdef SD_WRITE_CRC16_EN
        chk("crc_cmd_byte5", cap[5], 8'h6F);
        chk("crc_field", {cap[521], cap[522]}, crc16_model());
`else
        chk("nocrc_cmd_byte5", cap[5], 8'hFF);
        chk("nocrc_field", {cap[521], cap[522]}, 16'hFFFF);
`endif
        end_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
